// File: rtl/clint_access.sv
// clint_access: turns 64-bit timer requests into ordered 32-bit CLINT bus transactions.
// Optional WAIT timeout is enabled by defining CLINT_ACCESS_TIMEOUT_EN.
module clint_access #(
    parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_sel,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        clint_valid,
    output logic        clint_instr,
    output logic [31:0] clint_addr,
    output logic [31:0] clint_wdata,
    output logic [3:0]  clint_wstrb,
    input  logic [31:0] clint_rdata,
    input  logic        clint_ready
);
    localparam logic [1:0]  SEL_MSIP     = 2'd0;
    localparam logic [1:0]  SEL_MTIME    = 2'd2;
    localparam logic [1:0]  SEL_BAD      = 2'd3;
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;
    localparam int unsigned TCW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TCNT_MAX  = TCW'(TIMEOUT_CYCLES);

`ifdef CLINT_ACCESS_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t          r_state, w_state_d;
    logic            r_write;
    logic [1:0]      r_sel;
    logic [63:0]     r_wdata;
    logic [1:0]      r_step;
    logic [3:0]      r_retry;
    logic [31:0]     r_hi1;
    logic [31:0]     r_lo;
    logic [63:0]     r_rdata;
    logic            r_err;
    logic [TCW-1:0]  r_tcnt;

    logic            w_rd64;
    logic [1:0]      w_last_step;
    logic            w_last;
    logic            w_hi_diff;
    logic            w_retry_ok;
    logic            w_timeout;
    logic [15:0]     w_off;
    logic [31:0]     w_wdat;
    logic            w_bus_act;

    assign w_rd64      = !r_write && (r_sel != SEL_MSIP);
    assign w_last_step = (r_sel == SEL_MSIP) ? 2'd0 :
                         (r_write && r_sel == SEL_MTIME) ? 2'd1 : 2'd2;
    assign w_last      = (r_step == w_last_step);
    assign w_hi_diff   = (clint_rdata != r_hi1);
    assign w_retry_ok  = ({28'b0, r_retry} < MAX_RETRY);
    assign w_timeout   = TIMEOUT_EN && (r_tcnt == TCNT_MAX);
    assign w_bus_act   = (r_state == StIssue) || (r_state == StWait);

    // Address and write word of the current step; held stable through WAIT.
    always_comb begin
        w_off  = OFF_MSIP;
        w_wdat = 32'h0;
        if (r_sel == SEL_MSIP) begin
            w_wdat = {31'b0, r_wdata[0]};
        end else if (r_write && r_sel == SEL_MTIME) begin
            w_off  = (r_step == 2'd0) ? OFF_MTIME_LO : OFF_MTIME_HI;
            w_wdat = (r_step == 2'd0) ? r_wdata[31:0] : r_wdata[63:32];
        end else if (r_write) begin
            case (r_step)
                2'd0:    begin w_off = OFF_CMP_LO; w_wdat = 32'hFFFF_FFFF;   end
                2'd1:    begin w_off = OFF_CMP_HI; w_wdat = r_wdata[63:32]; end
                default: begin w_off = OFF_CMP_LO; w_wdat = r_wdata[31:0];  end
            endcase
        end else if (r_step == 2'd1) begin
            w_off = (r_sel == SEL_MTIME) ? OFF_MTIME_LO : OFF_CMP_LO;
        end else begin
            w_off = (r_sel == SEL_MTIME) ? OFF_MTIME_HI : OFF_CMP_HI;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 64'h0;
        resp_err    = 1'b0;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'h0;
        if (w_bus_act) begin
            clint_addr  = CLINT_BASE + {16'h0, w_off};
            clint_wdata = r_write ? w_wdat : 32'h0;
            clint_wstrb = r_write ? 4'hF : 4'h0;
        end
        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) w_state_d = (req_sel == SEL_BAD) ? StDone : StIssue;
            end
            StIssue: begin
                clint_valid = 1'b1;
                w_state_d   = StWait;
            end
            StWait: begin
                if (clint_ready) begin
                    if (!w_last || (w_rd64 && w_hi_diff && w_retry_ok)) w_state_d = StIssue;
                    else w_state_d = StDone;
                end else if (w_timeout) begin
                    w_state_d = StDone;
                end
            end
            default: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                w_state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_sel   <= 2'd0;
            r_wdata <= 64'h0;
            r_step  <= 2'd0;
            r_retry <= 4'd0;
            r_hi1   <= 32'h0;
            r_lo    <= 32'h0;
            r_rdata <= 64'h0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tcnt <= '0;
                    if (req_valid) begin
                        r_write <= req_write;
                        r_sel   <= req_sel;
                        r_wdata <= req_wdata;
                        r_step  <= 2'd0;
                        r_retry <= 4'd0;
                        r_rdata <= 64'h0;
                        r_err   <= (req_sel == SEL_BAD);
                    end
                end
                StIssue: r_tcnt <= '0;
                StWait: begin
                    if (clint_ready) begin
                        if (!r_write && r_step == 2'd0) r_hi1 <= clint_rdata;
                        if (!r_write && r_step == 2'd1) r_lo  <= clint_rdata;
                        if (!w_last) begin
                            r_step <= r_step + 2'd1;
                        end else if (w_rd64) begin
                            r_rdata <= {clint_rdata, r_lo};
                            if (w_hi_diff) begin
                                if (w_retry_ok) begin
                                    r_retry <= r_retry + 4'd1;
                                    r_step  <= 2'd0;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                        end else if (!r_write) begin
                            r_rdata <= {32'h0, clint_rdata};
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCW'(1);
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_rdata <= 64'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_access.sv
// Scoreboard bench for clint_access: expected bus transactions and responses are queued by
// the stimulus and checked by a monitor whenever the DUT strobes clint_valid or resp_valid.
module tb_clint_access;
    localparam int unsigned TimeoutCycles = 16;
    localparam logic [31:0] Base = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_sel;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        clint_valid, clint_instr, clint_ready;
    logic [31:0] clint_addr, clint_wdata, clint_rdata;
    logic [3:0]  clint_wstrb;

    clint_access #(
        .CLINT_BASE     (Base),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_sel     (req_sel),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    bus_t        bus_q[$];
    resp_t       resp_q[$];
    logic [31:0] rd_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          rsp_silent = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Responder: answers each transaction one cycle after its strobe.
    initial begin
        bit pend;
        bit pend_rd;
        pend = 1'b0;
        pend_rd = 1'b0;
        clint_ready = 1'b0;
        clint_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            clint_ready = pend;
            clint_rdata = 32'h0;
            if (pend && pend_rd) clint_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            pend    = clint_valid && !rsp_silent && !reset;
            pend_rd = (clint_wstrb == 4'h0);
        end
    end

    // Monitor: pops the scoreboard on every DUT strobe.
    initial forever begin
        bus_t  eb;
        resp_t er;
        @(negedge clock);
        if (!reset && clint_valid) begin
            n_checks = n_checks + 1;
            if (bus_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL bus_txn: unexpected addr=%h wdata=%h wstrb=%h, required none",
                         clint_addr, clint_wdata, clint_wstrb);
            end else begin
                eb = bus_q.pop_front();
                if (clint_addr !== eb.addr || clint_wdata !== eb.wdata ||
                    clint_wstrb !== eb.wstrb || clint_instr !== 1'b0) begin
                    n_errors = n_errors + 1;
                    $display("FAIL bus_txn: got addr=%h wdata=%h wstrb=%h instr=%b, required addr=%h wdata=%h wstrb=%h instr=0",
                             clint_addr, clint_wdata, clint_wstrb, clint_instr,
                             eb.addr, eb.wdata, eb.wstrb);
                end
            end
        end
        if (!reset && resp_valid) begin
            n_checks = n_checks + 1;
            if (resp_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL resp: unexpected rdata=%h err=%b, required none", resp_rdata, resp_err);
            end else begin
                er = resp_q.pop_front();
                if (resp_rdata !== er.rdata || resp_err !== er.err || (er.cyc >= 0 && cyc != er.cyc)) begin
                    n_errors = n_errors + 1;
                    $display("FAIL resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             resp_rdata, resp_err, cyc, er.rdata, er.err, er.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic exp_bus(input logic [15:0] off, input logic [31:0] wd, input logic wr);
        bus_q.push_back('{Base + {16'h0, off}, wd, wr ? 4'hF : 4'h0});
    endtask

    // Issue one request; lat counts the accept cycle as cycle 1 (negative: latency unchecked).
    task automatic do_req(input logic wr, input logic [1:0] sel, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_err, input int lat,
                          input int hold);
        int acc;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clock);
        if (!req_ready) chk("req_ready_wait", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1;
        req_write = wr;
        req_sel   = sel;
        req_wdata = wd;
        acc = cyc;
        resp_q.push_back('{exp_rd, exp_err, (lat < 0) ? -1 : acc + lat - 1});
        @(negedge clock);
        // Busy-time request must be dropped, not queued.
        req_write = 1'b1;
        req_sel   = 2'd0;
        req_wdata = 64'h1;
        repeat (hold) @(negedge clock);
        req_valid = 1'b0;
        for (int i = 0; i < 300 && resp_q.size() != 0; i++) @(negedge clock);
        if (resp_q.size() != 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL resp_timeout: got %0d pending responses, required 0", resp_q.size());
            resp_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_sel   = 2'd0;
        req_wdata = 64'h0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_clint_valid", {63'h0, clint_valid}, 64'h0);
        chk("rst_clint_addr", {32'h0, clint_addr}, 64'h0);
        chk("rst_resp_rdata", resp_rdata, 64'h0);
        reset = 1'b0;
        @(negedge clock);

        // msip write 1
        exp_bus(16'h0000, 32'h1, 1'b1);
        do_req(1'b1, 2'd0, 64'h1, 64'h0, 1'b0, 4, 0);

        // msip read; upper result word is zero
        exp_bus(16'h0000, 32'h0, 1'b0);
        rd_q.push_back(32'h0000_0001);
        do_req(1'b0, 2'd0, 64'h0, 64'h1, 1'b0, 4, 0);

        // mtime read, stable hi; request held high while busy is ignored
        exp_bus(16'hBFFC, 0, 0); exp_bus(16'hBFF8, 0, 0); exp_bus(16'hBFFC, 0, 0);
        rd_q.push_back(32'h0); rd_q.push_back(32'h5); rd_q.push_back(32'h0);
        do_req(1'b0, 2'd2, 64'h0, 64'h5, 1'b0, 8, 3);

        // mtime read with rollover: one retry
        for (int p = 0; p < 2; p++) begin
            exp_bus(16'hBFFC, 0, 0); exp_bus(16'hBFF8, 0, 0); exp_bus(16'hBFFC, 0, 0);
        end
        rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
        rd_q.push_back(32'h1); rd_q.push_back(32'h2); rd_q.push_back(32'h1);
        do_req(1'b0, 2'd2, 64'h0, 64'h0000_0001_0000_0002, 1'b0, 14, 0);

        // mtimecmp write: lo all-ones, hi, lo
        exp_bus(16'h4000, 32'hFFFF_FFFF, 1'b1);
        exp_bus(16'h4004, 32'h0000_0001, 1'b1);
        exp_bus(16'h4000, 32'h0000_0010, 1'b1);
        do_req(1'b1, 2'd1, 64'h0000_0001_0000_0010, 64'h0, 1'b0, 8, 0);

        // mtime write: lo then hi
        exp_bus(16'hBFF8, 32'h9ABC_DEF0, 1'b1);
        exp_bus(16'hBFFC, 32'h1234_5678, 1'b1);
        do_req(1'b1, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 6, 0);

        // mtimecmp read
        exp_bus(16'h4004, 0, 0); exp_bus(16'h4000, 0, 0); exp_bus(16'h4004, 0, 0);
        rd_q.push_back(32'h7); rd_q.push_back(32'h8); rd_q.push_back(32'h7);
        do_req(1'b0, 2'd1, 64'h0, 64'h0000_0007_0000_0008, 1'b0, 8, 0);

        // hi changes on every pass: 4 passes, then error with last {hi2, lo}
        for (int p = 0; p < 4; p++) begin
            exp_bus(16'hBFFC, 0, 0); exp_bus(16'hBFF8, 0, 0); exp_bus(16'hBFFC, 0, 0);
            rd_q.push_back(32'(2 * p + 1));
            rd_q.push_back(32'(10 + p));
            rd_q.push_back(32'(2 * p + 2));
        end
        do_req(1'b0, 2'd2, 64'h0, 64'h0000_0008_0000_000D, 1'b1, 26, 0);

        // following request accepted normally; msip uses bit 0 only
        exp_bus(16'h0000, 32'h0, 1'b1);
        do_req(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 4, 0);

        // illegal sel: no bus traffic
        do_req(1'b1, 2'd3, 64'h1234, 64'h0, 1'b1, -1, 0);
        do_req(1'b0, 2'd3, 64'h0, 64'h0, 1'b1, -1, 0);

`ifdef CLINT_ACCESS_TIMEOUT_EN
        rsp_silent = 1'b1;
        exp_bus(16'hBFFC, 0, 0);
        do_req(1'b0, 2'd2, 64'h0, 64'h0, 1'b1, TimeoutCycles + 4, 0);
        rsp_silent = 1'b0;
`endif

        // reset asserted while stuck in WAIT: immediate idle, no response
        rsp_silent = 1'b1;
        exp_bus(16'hBFFC, 0, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_sel   = 2'd2;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("wait_before_reset_ready", {63'h0, req_ready}, 64'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("async_rst_clint_addr", {32'h0, clint_addr}, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        rsp_silent = 1'b0;
        repeat (8) @(negedge clock);
        chk("post_rst_req_ready", {63'h0, req_ready}, 64'h1);

        chk("bus_q_drained", 64'(bus_q.size()), 64'h0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1);
    end
endmodule
